// File: rtl/slope_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : slope_div_arbiter
// Brief    : Round-robin sharing of one 16Q.16 slope divider among NUM_REQ
//            envelope-segment requesters. Defining SLOPE_ARB_CACHE_EN adds a
//            per-requester result cache that bypasses the divider on repeats.
// Revision : 1.0 - initial release
// ============================================================================
module slope_div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GNT_W   = 2
) (
  input  logic                  Sys_clk,
  input  logic                  Env_rst_n,
  input  logic                  Env_ce,
  input  logic [NUM_REQ-1:0]    Req,
  input  logic [NUM_REQ*32-1:0] Req_rise,
  input  logic [NUM_REQ*32-1:0] Req_run,
  output logic [NUM_REQ-1:0]    Ack,
  output logic [31:0]           Slope,
  output logic                  Busy,
  output logic                  Div_ce,
  output logic                  Div_sclr,
  output logic                  Div_nd,
  output logic [31:0]           Div_dividend,
  output logic [31:0]           Div_divisor,
  input  logic                  Div_rfd,
  input  logic                  Div_rdy,
  input  logic [31:0]           Div_quotient
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [GNT_W:0]     c_num_req  = (GNT_W+1)'(NUM_REQ);
  localparam logic [GNT_W-1:0]   c_last_req = GNT_W'(NUM_REQ-1);
  localparam logic [NUM_REQ-1:0] c_ack_one  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_sclr;
  logic [GNT_W-1:0]    r_grant;
  logic [GNT_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0]  r_ack;
  logic [31:0]         r_slope;
  logic [31:0]         r_dividend;
  logic [31:0]         r_divisor;

  logic [31:0]         w_rise [NUM_REQ];
  logic [31:0]         w_run  [NUM_REQ];
  logic [GNT_W:0]      w_idx;
  logic [GNT_W-1:0]    w_pick;
  logic                w_any;
  logic [31:0]         w_sel_rise;
  logic [31:0]         w_sel_run;
  logic [31:0]         w_sat;
  logic                w_hit;
  logic [31:0]         w_hit_slope;
  logic                w_div_ce;
  logic                w_div_nd;
  logic                w_res_wr;
  logic [31:0]         w_res_slope;
  logic                w_hit_load;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_rise[g] = Req_rise[32*g +: 32];
    assign w_run[g]  = Req_run[32*g +: 32];
  end

  // Search upward from the pointer with wrap; the pointer sits one past the last grant.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_ptr} + (GNT_W+1)'(i);
      if (w_idx >= c_num_req) w_idx = w_idx - c_num_req;
      if (!w_any && Req[w_idx[GNT_W-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[GNT_W-1:0];
      end
    end
  end

  assign w_sel_rise = w_rise[w_pick];
  assign w_sel_run  = w_run[w_pick];
  assign w_sat      = w_sel_rise[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;

`ifdef SLOPE_ARB_CACHE_EN
  logic [31:0]        r_c_rise  [NUM_REQ];
  logic [31:0]        r_c_run   [NUM_REQ];
  logic [31:0]        r_c_slope [NUM_REQ];
  logic [NUM_REQ-1:0] r_c_valid;

  assign w_hit       = r_c_valid[w_pick] && (r_c_rise[w_pick] == w_sel_rise) &&
                       (r_c_run[w_pick] == w_sel_run);
  assign w_hit_slope = r_c_slope[w_pick];

  always_ff @(posedge Sys_clk or negedge Env_rst_n) begin
    if (!Env_rst_n) begin
      r_c_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_c_rise[i]  <= '0;
        r_c_run[i]   <= '0;
        r_c_slope[i] <= '0;
      end
    end else if (w_res_wr) begin
      // Saturated results are written from IDLE, divider results from WAIT.
      if (r_state == S_IDLE) begin
        r_c_rise[w_pick]  <= w_sel_rise;
        r_c_run[w_pick]   <= w_sel_run;
        r_c_slope[w_pick] <= w_res_slope;
        r_c_valid[w_pick] <= 1'b1;
      end else begin
        r_c_rise[r_grant]  <= r_dividend;
        r_c_run[r_grant]   <= r_divisor;
        r_c_slope[r_grant] <= w_res_slope;
        r_c_valid[r_grant] <= 1'b1;
      end
    end
  end
`else
  assign w_hit       = 1'b0;
  assign w_hit_slope = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_div_ce    = 1'b0;
    w_div_nd    = 1'b0;
    w_res_wr    = 1'b0;
    w_res_slope = Div_quotient;
    w_hit_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          if (w_sel_run == 32'd0) begin
            w_state_nxt = S_DONE;
            w_res_wr    = 1'b1;
            w_res_slope = w_sat;
          end else if (w_hit) begin
            w_state_nxt = S_DONE;
            w_hit_load  = 1'b1;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_div_ce = 1'b1;
        if (Div_rfd) begin
          w_div_nd    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_div_ce = 1'b1;
        if (Div_rdy) begin
          w_state_nxt = S_DONE;
          w_res_wr    = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // A low enable freezes the whole block, divider included.
    if (!Env_ce) begin
      w_state_nxt = r_state;
      w_div_ce    = 1'b0;
      w_div_nd    = 1'b0;
      w_res_wr    = 1'b0;
      w_hit_load  = 1'b0;
    end
  end

  always_ff @(posedge Sys_clk or negedge Env_rst_n) begin
    if (!Env_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Clear is held through reset and one cycle beyond so an in-flight divide aborts.
  always_ff @(posedge Sys_clk or negedge Env_rst_n) begin
    if (!Env_rst_n) r_sclr <= 1'b1;
    else            r_sclr <= 1'b0;
  end

  always_ff @(posedge Sys_clk or negedge Env_rst_n) begin
    if (!Env_rst_n) begin
      r_grant    <= '0;
      r_ptr      <= '0;
      r_ack      <= '0;
      r_slope    <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
    end else if (Env_ce) begin
      r_ack <= '0;
      if (r_state == S_IDLE && w_any) begin
        r_grant    <= w_pick;
        r_dividend <= w_sel_rise;
        r_divisor  <= w_sel_run;
      end
      if (w_res_wr)        r_slope <= w_res_slope;
      else if (w_hit_load) r_slope <= w_hit_slope;
      if (r_state == S_DONE) begin
        if (Req[r_grant]) r_ack <= c_ack_one << r_grant;
        r_ptr <= (r_grant == c_last_req) ? '0 : r_grant + GNT_W'(1);
      end
    end
  end

  assign Ack          = r_ack;
  assign Slope        = r_slope;
  assign Busy         = (r_state != S_IDLE);
  assign Div_ce       = w_div_ce;
  assign Div_nd       = w_div_nd;
  assign Div_sclr     = r_sclr;
  assign Div_dividend = r_dividend;
  assign Div_divisor  = r_divisor;

endmodule
`default_nettype wire
